// File: rtl/openframe_pkg.sv
// Shared constants for the openframe boot/console wrapper: pad assignments,
// SPI flash opcodes and the boot sequencer state encoding.
package openframe_pkg;

  localparam int unsigned NUM_GPIO = 44;

  localparam int unsigned PIN_SCK  = 0;
  localparam int unsigned PIN_CSN  = 1;
  localparam int unsigned PIN_IO0  = 2;
  localparam int unsigned PIN_IO1  = 3;
  localparam int unsigned PIN_IO2  = 4;
  localparam int unsigned PIN_IO3  = 5;
  localparam int unsigned PIN_TX   = 6;
  localparam int unsigned PIN_RX   = 7;
  localparam int unsigned PIN_CLK  = 38;
  localparam int unsigned PIN_RSTN = 40;

  localparam logic [7:0] CMD_WAKE = 8'hAB;
  localparam logic [7:0] CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_WAKE,
    ST_GAP,
    ST_CMD,
    ST_READ,
    ST_TX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/openframe_project_wrapper_uart_tx.sv
// 8N1 UART transmitter; accepts a byte when idle and holds each bit for
// exactly BAUD_DIV clocks, returning to idle right after the stop bit.
module uart_tx #(
  parameter int unsigned BAUD_DIV = 218
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [9:0]    sh_q;
  logic          busy_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '1;
      busy_q <= 1'b0;
      tx     <= 1'b1;
    end else if (!busy_q) begin
      if (valid) begin
        sh_q   <= {1'b1, data, 1'b0};
        tx     <= 1'b0;
        busy_q <= 1'b1;
        baud_q <= '0;
        bit_q  <= '0;
      end
    end else if (baud_q == CW'(BAUD_DIV - 1)) begin
      baud_q <= '0;
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
      end else begin
        // sh_q[1] is the next frame bit; stop bit shifts in from the top
        bit_q <= bit_q + 4'd1;
        sh_q  <= {1'b1, sh_q[9:1]};
        tx    <= sh_q[1];
      end
    end else begin
      baud_q <= baud_q + CW'(1);
    end
  end

  assign ready = !busy_q;

endmodule

// File: rtl/openframe_project_wrapper.sv
// Openframe user-project wrapper: wakes an SPI NOR flash, reads a
// zero-terminated string and streams it out of the UART TX pad.
module openframe_project_wrapper
  import openframe_pkg::*;
#(
  parameter logic [23:0] FLASH_ADDR = 24'h100000,
  parameter int unsigned MAX_BYTES  = 256,
  parameter int unsigned BAUD_DIV   = 218,
  parameter int unsigned CS_GAP     = 16
) (
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oeb
);

  logic clk, resetn, miso;
  assign clk    = gpio_in[PIN_CLK];
  assign resetn = gpio_in[PIN_RSTN];
  assign miso   = gpio_in[PIN_IO1];

  logic unused_pins;
  assign unused_pins = ^{gpio_in[43:41], gpio_in[39], gpio_in[37:4], gpio_in[2:0]};

  state_e      state_q, state_d;
  logic        sck_q, sck_d, csn_q, csn_d, ph_q, ph_d;
  logic        launched_q, launched_d;
  logic [31:0] sh_q, sh_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  rx_q, rx_d;
  logic [8:0]  count_q, count_d;
  logic        last_bit, shift_done;
  logic        uart_valid, uart_ready, tx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_WAIT;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_q      <= 1'b0;
      csn_q      <= 1'b1;
      ph_q       <= 1'b0;
      launched_q <= 1'b0;
      sh_q       <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      rx_q       <= '0;
      count_q    <= '0;
    end else begin
      sck_q      <= sck_d;
      csn_q      <= csn_d;
      ph_q       <= ph_d;
      launched_q <= launched_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      rx_q       <= rx_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sck_d      = sck_q;
    csn_d      = csn_q;
    ph_d       = ph_q;
    launched_d = launched_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    rx_d       = rx_q;
    count_d    = count_q;
    uart_valid = (state_q == ST_TX) && !launched_q;
    last_bit   = (state_q == ST_CMD) ? (cnt_q == 6'd31) : (cnt_q == 6'd7);
    shift_done = 1'b0;

    // Shared SPI bit engine: L phase (sck low, MOSI stable) then H phase;
    // MISO is captured on the edge that drops sck.
    if (state_q inside {ST_WAKE, ST_CMD, ST_READ}) begin
      if (!ph_q) begin
        sck_d = 1'b1;
        ph_d  = 1'b1;
      end else begin
        sck_d      = 1'b0;
        ph_d       = 1'b0;
        rx_d       = {rx_q[6:0], miso};
        sh_d       = {sh_q[30:0], 1'b0};
        cnt_d      = cnt_q + 6'd1;
        shift_done = last_bit;
      end
    end

    unique case (state_q)
      ST_WAIT: begin
        if (gap_q == 16'(CS_GAP - 1)) begin
          state_d = ST_WAKE;
          csn_d   = 1'b0;
          sh_d    = {CMD_WAKE, 24'h0};
          cnt_d   = '0;
          ph_d    = 1'b0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      ST_WAKE: begin
        if (shift_done) begin
          state_d = ST_GAP;
          csn_d   = 1'b1;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == 16'(CS_GAP - 1)) begin
          state_d = ST_CMD;
          csn_d   = 1'b0;
          sh_d    = {CMD_READ, FLASH_ADDR};
          cnt_d   = '0;
          ph_d    = 1'b0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      ST_CMD: begin
        if (shift_done) begin
          state_d = ST_READ;
          sh_d    = '0;
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        // Decision uses the byte completed on this very edge (rx_d)
        if (shift_done) begin
          if (rx_d == 8'h00 || count_q == 9'(MAX_BYTES)) begin
            state_d = ST_DONE;
            csn_d   = 1'b1;
          end else begin
            state_d    = ST_TX;
            launched_d = 1'b0;
            count_d    = (count_q == '1) ? count_q : count_q + 9'd1;
          end
        end
      end
      ST_TX: begin
        if (!launched_q) begin
          if (uart_ready) launched_d = 1'b1;
        end else if (uart_ready) begin
          state_d = ST_READ;
          cnt_d   = '0;
          ph_d    = 1'b0;
          sh_d    = '0;
        end
      end
      ST_DONE: begin
        csn_d = 1'b1;
        sck_d = 1'b0;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk   (clk),
    .resetn(resetn),
    .data  (rx_q),
    .valid (uart_valid),
    .ready (uart_ready),
    .tx    (tx)
  );

  always_comb begin
    gpio_out          = '0;
    gpio_out[PIN_SCK] = sck_q;
    gpio_out[PIN_CSN] = csn_q;
    gpio_out[PIN_IO0] = sh_q[31];
    gpio_out[PIN_IO2] = 1'b1;
    gpio_out[PIN_IO3] = 1'b1;
    gpio_out[PIN_TX]  = tx;

    gpio_oeb          = '1;
    gpio_oeb[PIN_SCK] = 1'b0;
    gpio_oeb[PIN_CSN] = 1'b0;
    gpio_oeb[PIN_IO0] = 1'b0;
    gpio_oeb[PIN_IO2] = 1'b0;
    gpio_oeb[PIN_IO3] = 1'b0;
    gpio_oeb[PIN_TX]  = 1'b0;
  end

endmodule

// File: tb/tb_openframe_project_wrapper.sv
// Bench for the openframe wrapper: behavioural SPI flash, SPI sniffer and a
// UART scoreboard; a second instance with a short baud runs the 256-byte case.
module tb_openframe_project_wrapper;

  logic        clk = 1'b0;
  logic        rstn [2];
  logic        io1  [2];
  logic [43:0] gin  [2];
  logic [43:0] gout [2];
  logic [43:0] goeb [2];
  logic [7:0]  mem  [2][0:511];

  logic [7:0]  exp0 [$];
  logic [7:0]  exp1 [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          started [2];
  int          done    [2];

  int          sn_n = 0;
  int          sn_per_err = 0;
  int          sn_bits [4];
  int          sn_gap  [4];
  logic [31:0] sn_first [4];
  logic [31:0] sn_last  [4];

  always #5 clk = ~clk;

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      gin[g]     = '0;
      gin[g][38] = clk;
      gin[g][40] = rstn[g];
      gin[g][3]  = io1[g];
    end
  end

  openframe_project_wrapper u_dut (
    .gpio_in (gin[0]),
    .gpio_out(gout[0]),
    .gpio_oeb(goeb[0])
  );

  openframe_project_wrapper #(
    .BAUD_DIV(8)
  ) u_fast (
    .gpio_in (gin[1]),
    .gpio_out(gout[1]),
    .gpio_oeb(goeb[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] flash_byte(input int g, input logic [23:0] a);
    logic [23:0] off;
    off = a - 24'h100000;
    if (off < 24'd512) return mem[g][off[8:0]];
    return 8'hFF;
  endfunction

  task automatic flash_model(input int g);
    logic psck, sck, csn, mosi, awake, reading;
    logic [31:0] cmd;
    logic [23:0] addr;
    logic [7:0]  b;
    int nb, bi;
    psck = 1'b0; awake = 1'b0; reading = 1'b0; cmd = '0; addr = '0; nb = 0; bi = 7;
    io1[g] = 1'b0;
    forever begin
      @(negedge clk);
      sck = gout[g][0]; csn = gout[g][1]; mosi = gout[g][2];
      if (csn !== 1'b0) begin
        nb = 0;
        reading = 1'b0;
      end else if (psck === 1'b0 && sck === 1'b1 && !reading) begin
        cmd = {cmd[30:0], mosi};
        nb++;
        if (nb == 8 && cmd[7:0] == 8'hAB) awake = 1'b1;
        if (nb == 32 && awake && cmd[31:24] == 8'h03) begin
          reading = 1'b1;
          addr = cmd[23:0];
          bi = 7;
        end
      end else if (psck === 1'b1 && sck === 1'b0 && reading) begin
        b = flash_byte(g, addr);
        io1[g] = b[bi];
        if (bi == 0) begin
          bi = 7;
          addr++;
        end else begin
          bi--;
        end
      end
      psck = sck;
    end
  endtask

  task automatic sniffer();
    logic psck, pcsn, sck, csn, mosi;
    logic [31:0] sh, first;
    int nb, hi, cyc, lastr;
    psck = 1'b0; pcsn = 1'b1; sh = '0; first = '0; nb = 0; hi = 0; cyc = 0; lastr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      sck = gout[0][0]; csn = gout[0][1]; mosi = gout[0][2];
      if (csn === 1'b0) begin
        if (pcsn === 1'b1) begin
          nb = 0; sh = '0; first = '0;
          if (sn_n < 4) sn_gap[sn_n] = hi;
        end
        if (psck === 1'b0 && sck === 1'b1) begin
          sh = {sh[30:0], mosi};
          nb++;
          if (nb <= 32) first = sh;
          if (nb > 1 && nb <= 32 && cyc - lastr != 2) sn_per_err++;
          lastr = cyc;
        end
      end else begin
        if (pcsn === 1'b0 && sn_n < 4) begin
          sn_bits[sn_n]  = nb;
          sn_first[sn_n] = first;
          sn_last[sn_n]  = sh;
          sn_n++;
        end
        hi = (pcsn === 1'b1) ? hi + 1 : 1;
      end
      psck = sck; pcsn = csn;
    end
  endtask

  task automatic uart_mon(input int g, input int div);
    logic [9:0] want, got;
    logic [7:0] b;
    int bad;
    bit ok, aborted;
    forever begin
      @(negedge clk);
      if (rstn[g] === 1'b1 && gout[g][6] === 1'b0) begin
        started[g]++;
        ok = 1'b1;
        b = 8'h00;
        if (g == 0) begin
          if (exp0.size() > 0) b = exp0.pop_front(); else ok = 1'b0;
        end else begin
          if (exp1.size() > 0) b = exp1.pop_front(); else ok = 1'b0;
        end
        if (!ok) begin
          vectors++;
          miscompares++;
          $display("FAIL uart%0d unexpected frame: got start bit, required idle line", g);
        end
        want = {1'b1, b, 1'b0};
        got = '0; bad = 0; aborted = 1'b0;
        for (int i = 0; i < 10 * div; i++) begin
          if (i > 0) @(negedge clk);
          if (rstn[g] !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (gout[g][6] !== want[i / div]) bad++;
          if (i % div == div / 2) got[i / div] = gout[g][6];
        end
        if (!aborted) begin
          done[g]++;
          if (ok) begin
            check($sformatf("uart%0d frame %0d bits", g, done[g]), 64'(got), 64'(want));
            check($sformatf("uart%0d frame %0d bit timing errors", g, done[g]), 64'(bad), 64'd0);
          end
        end
      end
    end
  endtask

  task automatic wait_frames(input int g, input bit use_done, input int n, input int budget);
    int c = 0;
    while (((use_done ? done[g] : started[g]) < n) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check($sformatf("uart%0d frame count (%s)", g, use_done ? "done" : "started"),
          64'(use_done ? done[g] : started[g]), 64'(n));
  endtask

  task automatic push_hi();
    exp0.push_back(8'h48);
    exp0.push_back(8'h69);
    exp0.push_back(8'h0A);
  endtask

  initial begin
    rstn[0] = 1'b0; rstn[1] = 1'b0;
    started[0] = 0; started[1] = 0; done[0] = 0; done[1] = 0;
    for (int i = 0; i < 512; i++) begin
      mem[0][i] = 8'hFF;
      mem[1][i] = (i < 300) ? 8'h41 : 8'hFF;
    end
    mem[0][0] = 8'h48; mem[0][1] = 8'h69; mem[0][2] = 8'h0A; mem[0][3] = 8'h00;

    fork
      uart_mon(0, 218);
      uart_mon(1, 8);
      flash_model(0);
      flash_model(1);
      sniffer();
    join_none

    repeat (100) @(negedge clk);
    check("reset gpio_out", 64'(gout[0]), 64'h72);
    check("reset gpio_oeb", 64'(goeb[0]), 64'hFFFFFFFFF88);
    check("reset gpio_out fast", 64'(gout[1]), 64'h72);
    check("reset gpio_oeb fast", 64'(goeb[1]), 64'hFFFFFFFFF88);

    push_hi();
    for (int i = 0; i < 256; i++) exp1.push_back(8'h41);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;

    wait_frames(0, 1'b1, 3, 20000);
    repeat (500) @(negedge clk);
    check("done csn", 64'(gout[0][1]), 64'd1);
    check("done sck", 64'(gout[0][0]), 64'd0);
    check("done tx", 64'(gout[0][6]), 64'd1);
    check("done frames", 64'(done[0]), 64'd3);
    check("done expected queue", 64'(exp0.size()), 64'd0);
    check("wake bits", 64'(sn_bits[0]), 64'd8);
    check("wake opcode", 64'(sn_first[0]), 64'hAB);
    check("csn gap >= 16", 64'(sn_gap[1] >= 16), 64'd1);
    check("read command", 64'(sn_first[1]), 64'h03100000);
    check("read transaction bits", 64'(sn_bits[1]), 64'd64);
    check("read phase mosi", 64'(sn_last[1]), 64'd0);
    check("sck period errors", 64'(sn_per_err), 64'd0);

    rstn[0] = 1'b0;
    repeat (10) @(negedge clk);
    push_hi();
    rstn[0] = 1'b1;
    wait_frames(0, 1'b0, 5, 10000);
    repeat (150) @(negedge clk);
    #3;
    rstn[0] = 1'b0;
    #1;
    check("async reset tx", 64'(gout[0][6]), 64'd1);
    check("async reset csn", 64'(gout[0][1]), 64'd1);
    check("async reset sck", 64'(gout[0][0]), 64'd0);
    check("async reset gpio_out", 64'(gout[0]), 64'h72);
    exp0.delete();
    @(negedge clk);
    repeat (10) @(negedge clk);
    push_hi();
    rstn[0] = 1'b1;
    wait_frames(0, 1'b1, 7, 20000);
    repeat (500) @(negedge clk);
    check("restart done frames", 64'(done[0]), 64'd7);
    check("restart expected queue", 64'(exp0.size()), 64'd0);
    check("restart done csn", 64'(gout[0][1]), 64'd1);

    wait_frames(1, 1'b1, 256, 60000);
    repeat (300) @(negedge clk);
    check("max bytes frames", 64'(done[1]), 64'd256);
    check("max bytes queue", 64'(exp1.size()), 64'd0);
    check("max bytes csn", 64'(gout[1][1]), 64'd1);
    check("max bytes tx", 64'(gout[1][6]), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
